// File: rtl/pwm.sv
// Programmable PWM generator: a prescaler divides clk by T into ticks; pulse is high for ontime ticks, then low for offtime ticks.
// Optional PWM_SYNC_UPDATE_EN: settings are sampled into shadow registers only at each period start.
module pwm #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned CNT_WIDTH = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] ontime,
    input  logic [WIDTH-1:0] offtime,
    output logic             pulse,
    input  logic [WIDTH-1:0] T
);

    typedef enum logic {
        ON  = 1'b0,
        OFF = 1'b1
    } phase_t;

    phase_t               phase, phase_n;
    logic [CNT_WIDTH-1:0] presc, presc_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic                 run;
    logic                 pulse_n;
    logic                 cap;

    logic [WIDTH-1:0]     on_s, off_s, t_s;
    logic [CNT_WIDTH-1:0] teff, cnt_inc;
    logic                 tick, on_done, off_done, on_live_nz;

`ifdef PWM_SYNC_UPDATE_EN
    logic [WIDTH-1:0] on_q, off_q, t_q;

    // Shadow copies, refreshed only when a new period begins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_q  <= '0;
            off_q <= '0;
            t_q   <= '0;
        end else if (cap) begin
            on_q  <= ontime;
            off_q <= offtime;
            t_q   <= T;
        end
    end

    assign on_s  = on_q;
    assign off_s = off_q;
    assign t_s   = t_q;
`else
    logic unused_cap;

    assign unused_cap = cap;
    assign on_s       = ontime;
    assign off_s      = offtime;
    assign t_s        = T;
`endif

    // Tick and phase-end decodes; >= keeps a lowered setting from wrapping the counters
    always_comb begin
        teff       = (t_s == '0) ? CNT_WIDTH'(1) : CNT_WIDTH'(t_s);
        tick       = (presc >= (teff - CNT_WIDTH'(1)));
        cnt_inc    = cnt + CNT_WIDTH'(1);
        on_done    = (cnt_inc >= CNT_WIDTH'(on_s));
        off_done   = (cnt_inc >= CNT_WIDTH'(off_s));
        on_live_nz = (ontime != '0);
    end

    // Next-state logic; pulse_n is the level for the coming cycle
    always_comb begin
        phase_n = phase;
        cnt_n   = cnt;
        pulse_n = pulse;
        cap     = 1'b0;
        presc_n = tick ? '0 : (presc + CNT_WIDTH'(1));

        if (!run) begin
            // First cycle after reset: start the ON phase without advancing the prescaler
            presc_n = presc;
            cnt_n   = '0;
            phase_n = ON;
            cap     = 1'b1;
            pulse_n = on_live_nz;
        end else begin
            case (phase)
                ON: begin
                    if (on_s == '0) begin
                        cnt_n = '0;
                        if (off_s != '0) begin
                            phase_n = OFF;
                            pulse_n = 1'b0;
                        end else begin
                            cap     = 1'b1;
                            pulse_n = on_live_nz;
                        end
                    end else if (tick) begin
                        if (on_done) begin
                            cnt_n = '0;
                            if (off_s == '0) begin
                                cap     = 1'b1;
                                pulse_n = on_live_nz;
                            end else begin
                                phase_n = OFF;
                                pulse_n = 1'b0;
                            end
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                OFF: begin
                    if ((off_s == '0) || (tick && off_done)) begin
                        phase_n = ON;
                        cnt_n   = '0;
                        cap     = 1'b1;
                        pulse_n = on_live_nz;
                    end else if (tick) begin
                        cnt_n = cnt_inc;
                    end
                end
                default: begin
                    phase_n = ON;
                    cnt_n   = '0;
                    pulse_n = 1'b0;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= ON;
            presc <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            phase <= phase_n;
            presc <= presc_n;
            cnt   <= cnt_n;
            run   <= 1'b1;
            pulse <= pulse_n;
        end
    end

endmodule

// File: tb/tb_pwm.sv
// Directed bench for pwm: expected high/low run lengths are queued per setup and compared against measured pulse runs.
module tb_pwm;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] ontime;
    logic [WIDTH-1:0] offtime;
    logic [WIDTH-1:0] T;
    logic             pulse;

    typedef struct {
        logic lvl;
        int   len;
    } seg_t;

    seg_t q[$];
    int   total;
    int   bad;

    pwm #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .ontime (ontime),
        .offtime(offtime),
        .pulse  (pulse),
        .T      (T)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int teff(input int t);
        return (t == 0) ? 1 : t;
    endfunction

    task automatic push(input logic lvl, input int len);
        seg_t s;
        s.lvl = lvl;
        s.len = len;
        q.push_back(s);
    endtask

    task automatic push_period(input int on, input int off, input int t);
        push(1'b1, on * teff(t));
        push(1'b0, off * teff(t));
    endtask

    // Reset, apply settings, release; leaves time at first sample point after release
    task automatic start(input int on, input int off, input int t);
        @(negedge clk);
        rst     = 1'b0;
        ontime  = WIDTH'(on);
        offtime = WIDTH'(off);
        T       = WIDTH'(t);
        @(negedge clk);
        total++;
        assert (pulse === 1'b0)
        else begin
            bad++;
            $error("FAIL reset_pulse observed=%b expected=0", pulse);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Pop each expected run and measure it; hold=1 means the run must last at least len
    task automatic drain(input string tag, input bit hold);
        seg_t s;
        int   n;
        int   lim;
        while (q.size() > 0) begin
            s   = q.pop_front();
            n   = 0;
            lim = hold ? s.len : s.len + 20;
            while ((pulse === s.lvl) && (n < lim)) begin
                n++;
                @(posedge clk);
                #1;
            end
            total++;
            assert (n === s.len)
            else begin
                bad++;
                $error("FAIL %s lvl=%b run observed=%0d expected=%0d", tag, s.lvl, n, s.len);
            end
        end
    endtask

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        rst     = 1'b0;
        ontime  = '0;
        offtime = '0;
        T       = '0;
        repeat (3) @(negedge clk);

        start(10, 5, 5);
        push_period(10, 5, 5);
        push_period(10, 5, 5);
        drain("base_10_5_t5", 1'b0);

        start(10, 5, 10);
        push_period(10, 5, 10);
        push(1'b1, 100);
        drain("t10", 1'b0);

        start(10, 5, 15);
        push_period(10, 5, 15);
        push(1'b1, 150);
        drain("t15", 1'b0);

        start(8, 7, 15);
        push_period(8, 7, 15);
        drain("duty_8_7", 1'b0);

        start(5, 10, 15);
        push_period(5, 10, 15);
        drain("duty_5_10", 1'b0);

        start(2, 13, 15);
        push_period(2, 13, 15);
        push(1'b1, 30);
        drain("duty_2_13", 1'b0);

        start(0, 5, 3);
        push(1'b0, 120);
        drain("on_zero", 1'b1);

        start(5, 0, 3);
        push(1'b1, 120);
        drain("off_zero", 1'b1);

        start(0, 0, 3);
        push(1'b0, 120);
        drain("both_zero", 1'b1);

        start(10, 5, 0);
        push_period(10, 5, 0);
        push_period(10, 5, 0);
        drain("t_zero", 1'b0);

        start(15, 15, 15);
        push_period(15, 15, 15);
        push(1'b1, 225);
        drain("max", 1'b0);

        // Asynchronous reset in the middle of the high phase
        start(10, 5, 5);
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        assert (pulse === 1'b0)
        else begin
            bad++;
            $error("FAIL async_reset observed=%b expected=0", pulse);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        push_period(10, 5, 5);
        drain("after_reset", 1'b0);

        // Lower ontime 10->2 once five ticks of the high phase have elapsed
        start(10, 5, 5);
        n = 0;
        while ((pulse === 1'b1) && (n < 80)) begin
            n++;
            if (n == 28) ontime = WIDTH'(2);
            @(posedge clk);
            #1;
        end
        total++;
`ifdef PWM_SYNC_UPDATE_EN
        assert (n === 50)
        else begin
            bad++;
            $error("FAIL lower_ontime high observed=%0d expected=50", n);
        end
`else
        assert (n === 30)
        else begin
            bad++;
            $error("FAIL lower_ontime high observed=%0d expected=30", n);
        end
`endif
        push(1'b0, 25);
        push_period(2, 5, 5);
        drain("lower_ontime", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm.md
Name: pwm

Overview:
Programmable PWM generator with a prescaled time base. A prescaler divides clk by T to produce a tick. The output pulse is high for ontime ticks and low for offtime ticks, then repeats. Frequency is set by T and the ontime/offtime sum; duty cycle is set by the ontime:offtime ratio. It sits beside control logic that drives the three settings as static-ish registers.

Parameters:
WIDTH, 4, bit width of ontime, offtime and T.
CNT_WIDTH, 2*WIDTH, width of internal prescaler and phase counters; must hold WIDTH-bit maximum values without overflow.

Ports:
(positional order is fixed: clk, rst, ontime, offtime, pulse, T)
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
ontime  input  WIDTH  high-phase length in ticks.
offtime  input  WIDTH  low-phase length in ticks.
pulse  output  1  registered PWM output.
T  input  WIDTH  prescaler divisor: clk cycles per tick.

Behaviour:
- Reset (rst=0, asynchronous): pulse=0, prescaler=0, phase counter=0, phase=ON, shadow registers=0. Reset may assert mid-period; it clears immediately, with no glitch beyond the forced 0.
- Effective divisor: Teff = (T==0) ? 1 : T.
- Prescaler: counts 0..Teff-1. A tick occurs in the cycle where prescaler==Teff-1; prescaler then wraps to 0. Use a >= compare so a lowered T takes effect without wrap-around.
- Phase FSM, states ON and OFF:
  - In ON, pulse=1. After ontime ticks, go to OFF with pulse=0.
  - In OFF, after offtime ticks, go to ON with pulse=1.
  - The phase counter clears on every phase change.
  - Phase-end compare uses >=, so a setting lowered mid-phase ends the phase on the next tick.
- Timing: the first rising edge after reset release sets pulse=1 (when ontime>0).
  - High lasts exactly ontime*Teff cycles; low lasts exactly offtime*Teff cycles.
  - Period = (ontime+offtime)*Teff cycles. No extra cycles are inserted at phase boundaries.
- Boundaries:
  - ontime==0, offtime>0: pulse held 0 permanently.
  - offtime==0, ontime>0: pulse held 1 permanently.
  - Both 0: pulse 0, phase counter idle, prescaler keeps running.
  - Maximum values (15,15,15): period 450 cycles, no overflow.
- All outputs are registered. No combinational path from inputs to pulse.

Optional Feature:
PWM_SYNC_UPDATE_EN
- Defined: ontime, offtime and T are captured into shadow registers only at the start of each period (the ON entry, including the first cycle after reset). The FSM and prescaler use only the shadow values, so every period is glitch-free and complete.
- Undefined: the live inputs are used directly, and changes affect the in-progress phase via the >= compares described above.

Test Plan:
- ontime=10, offtime=5, T=5 after reset release -> pulse high 50 cycles, low 25 cycles, period 75; the first high starts one edge after release.
- Change T to 10, then 15, keeping 10/5 -> periods 150 and 225, duty 66.7%; with PWM_SYNC_UPDATE_EN the change applies only at the next period start.
- Duty sweep at T=15: 8/7 -> 120 high/105 low; 5/10 -> 75/150; 2/13 -> 30/195 (13.3%).
- Corner cases:
  - ontime=0 -> pulse constant 0.
  - offtime=0 -> pulse constant 1.
  - Both 0 -> pulse 0.
  - T=0 behaves as T=1: 10/5 gives 10 high/5 low.
- Assert rst=0 mid-ON phase -> pulse drops to 0 asynchronously. On release, the full ontime*Teff high phase restarts from zero.
- Live mode: lower ontime from 10 to 2 while 5 ticks into ON -> ON ends at the next tick, with no counter wrap (pulse not stuck high).
